// File: rtl/boot_mem_pkg.sv
// Shared types for the boot-time SRAM arbiter.
// FSM states, requester ids and the default end-of-program marker.
package boot_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARMED = 2'd2,
      ST_RUN   = 2'd3
   } boot_state_e;

   typedef enum logic [1:0] {
      ID_LD   = 2'd0,
      ID_IF   = 2'd1,
      ID_DM   = 2'd2,
      ID_NONE = 2'd3
   } req_id_e;

   localparam logic [31:0] END_MARKER_DEF = 32'h0000_0fff;

endpackage

// File: rtl/boot_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter used for the core fetch/data ports.
// On a tie the side not granted last wins; reset favours side b.
module rr_arb2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   // Set when b should win the next tie.
   logic prio_b_q;

   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      if (en_i) begin
         if (req_a_i && req_b_i) begin
            gnt_a_o = !prio_b_q;
            gnt_b_o = prio_b_q;
         end else begin
            gnt_a_o = req_a_i;
            gnt_b_o = req_b_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_b_q <= 1'b1;
      end else if (gnt_a_o) begin
         prio_b_q <= 1'b1;
      end else if (gnt_b_o) begin
         prio_b_q <= 1'b0;
      end
   end

endmodule

// File: rtl/boot_mem_arbiter.sv
// Single-port SRAM arbiter for loader, fetch and data ports.
// Also sequences the load -> arm -> run boot handshake.
module boot_mem_arbiter
   import boot_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(END_MARKER_DEF),
   parameter int unsigned       CNT_W      = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ld_req_i,
   input  logic                ld_we_i,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   input  logic [DATA_W-1:0]   ld_wdata_i,
   output logic                ld_gnt_o,
   output logic                ld_rvalid_o,
   output logic [DATA_W-1:0]   ld_rdata_o,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_be_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic                dm_gnt_o,
   output logic                dm_rvalid_o,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                boot_go_i,
   input  logic                sw_rst_i,
   output logic                fetch_enable_o,
   output logic                boot_done_o,
   output logic [CNT_W-1:0]    ld_count_o,
   output logic [1:0]          state_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   boot_state_e state_q;
   boot_state_e state_d;
   req_id_e     gnt_id;
   req_id_e     rsp_id_q;
   logic        core_en;
   logic        if_gnt;
   logic        dm_gnt;
   logic        ld_wr;
   logic        ld_mark;

   // The loader always wins; the core only competes in RUN.
   assign core_en = (state_q == ST_RUN) && !ld_req_i;

   rr_arb2 u_rr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (core_en),
      .req_a_i (if_req_i),
      .req_b_i (dm_req_i),
      .gnt_a_o (if_gnt),
      .gnt_b_o (dm_gnt)
   );

   assign ld_gnt_o = ld_req_i;
   assign if_gnt_o = if_gnt;
   assign dm_gnt_o = dm_gnt;
   assign ld_wr    = ld_req_i && ld_we_i;
   assign ld_mark  = ld_wr && (ld_wdata_i == END_MARKER);

   always_comb begin
      gnt_id = ID_NONE;
      unique case (1'b1)
         ld_req_i: gnt_id = ID_LD;
         if_gnt:   gnt_id = ID_IF;
         dm_gnt:   gnt_id = ID_DM;
         default:  gnt_id = ID_NONE;
      endcase
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (gnt_id)
         ID_LD: begin
            mem_req_o   = 1'b1;
            mem_we_o    = ld_we_i;
            mem_be_o    = {BE_W{1'b1}};
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
         end
         ID_IF: begin
            mem_req_o  = 1'b1;
            mem_be_o   = {BE_W{1'b1}};
            mem_addr_o = if_addr_i;
         end
         ID_DM: begin
            mem_req_o   = 1'b1;
            mem_we_o    = dm_we_i;
            mem_be_o    = dm_we_i ? dm_be_i : {BE_W{1'b1}};
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
         end
         ID_NONE: begin
            mem_req_o = 1'b0;
         end
      endcase
   end

   // boot_go wins over a marker write landing in the same LOAD cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ld_mark)    state_d = ST_ARMED;
            else if (ld_wr) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (boot_go_i)    state_d = ST_RUN;
            else if (ld_mark) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (boot_go_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
      endcase
      if (sw_rst_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         rsp_id_q       <= ID_NONE;
         fetch_enable_o <= 1'b0;
         boot_done_o    <= 1'b0;
         ld_count_o     <= '0;
      end else begin
         state_q  <= state_d;
         rsp_id_q <= gnt_id;
         if (sw_rst_i) begin
            fetch_enable_o <= 1'b0;
            boot_done_o    <= 1'b0;
            ld_count_o     <= '0;
         end else begin
            if (state_d == ST_RUN) fetch_enable_o <= 1'b1;
            if (ld_mark)           boot_done_o    <= 1'b1;
            if (ld_wr && (ld_count_o != {CNT_W{1'b1}}))
               ld_count_o <= ld_count_o + CNT_W'(1);
         end
      end
   end

   assign ld_rvalid_o = (rsp_id_q == ID_LD);
   assign if_rvalid_o = (rsp_id_q == ID_IF);
   assign dm_rvalid_o = (rsp_id_q == ID_DM);
   assign ld_rdata_o  = ld_rvalid_o ? mem_rdata_i : '0;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
   assign state_o     = state_q;

endmodule

// File: doc/boot_mem_arbiter.md
Name: boot_mem_arbiter

Overview:
Owns the single-port program/data SRAM of top_core and sequences the boot handshake. Three requesters share the SRAM:
- the SPI loader port, fed by the SPI slave's write command (cmd 2);
- the core instruction-fetch port;
- the core data port.

Core access and fetch_enable_o are withheld until a program has been loaded and a go request arrives.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- END_MARKER, 32'h00000fff, loader write data value that marks the last program word
- CNT_W, 16, width of the loaded-word counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ld_req_i  in  1  loader request
- ld_we_i  in  1  loader write enable
- ld_addr_i  in  ADDR_W  loader address
- ld_wdata_i  in  DATA_W  loader write data
- ld_gnt_o  out  1  loader grant
- ld_rvalid_o  out  1  loader response valid
- ld_rdata_o  out  DATA_W  loader read data
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch grant
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_W  fetch data
- dm_req_i  in  1  data request
- dm_we_i  in  1  data write enable
- dm_be_i  in  DATA_W/8  data byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  data write data
- dm_gnt_o  out  1  data grant
- dm_rvalid_o  out  1  data response valid
- dm_rdata_o  out  DATA_W  data read data
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  DATA_W/8  SRAM byte enables
- mem_addr_o  out  ADDR_W  SRAM address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_rdata_i  in  DATA_W  SRAM read data (1-cycle latency)
- boot_go_i  in  1  request to start the core (level or pulse)
- sw_rst_i  in  1  return to IDLE from any state
- fetch_enable_o  out  1  core fetch enable (registered)
- boot_done_o  out  1  END_MARKER has been written (registered)
- ld_count_o  out  CNT_W  number of loader writes accepted since IDLE
- state_o  out  2  current FSM state

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - state=IDLE; fetch_enable_o=0, boot_done_o=0, ld_count_o=0.
  - All rvalid outputs 0; round-robin pointer set to favour dm; any pending response is dropped.
- FSM states: IDLE=0, LOAD=1, ARMED=2, RUN=3.
  - IDLE -> LOAD: on a granted loader write.
  - LOAD -> ARMED: on a granted loader write with ld_wdata_i==END_MARKER. boot_done_o=1 from the next cycle. A marker written directly from IDLE goes IDLE -> ARMED.
  - LOAD or ARMED -> RUN: on boot_go_i=1. fetch_enable_o=1 from the next cycle and stays high; a short boot_go_i pulse is sufficient.
  - IDLE ignores boot_go_i.
  - Any state -> IDLE: on sw_rst_i. Clears fetch_enable_o, boot_done_o and ld_count_o; a pending rvalid is still delivered.
- Grants are combinational in the same cycle as the request. At most one grant per cycle.
  - Loader has fixed highest priority in every state.
  - if/dm are never granted outside RUN.
  - In RUN, if/dm are round-robin: on a tie, the requester not granted last wins. The pointer updates only on an if/dm grant.
- Memory drive: mem_req_o = OR of grants. mem_we/be/addr/wdata are muxed from the winner. Loader be is all ones; if we=0, be all ones.
- Response: the granted id is registered and, one cycle later, exactly one rvalid pulses with rdata=mem_rdata_i. Writes also return rvalid. rdata of non-selected ports holds 0.
- ld_count_o increments on each granted loader write and saturates at all ones.
- A request not granted must be held by the requester; no queuing in this block.

Decomposition:
- Package boot_mem_pkg: state enum boot_state_e (IDLE/LOAD/ARMED/RUN), requester id enum req_id_e (LD/IF/DM/NONE), END_MARKER default.
- One sub-module, rr_arb2: two-way round-robin with a pointer, used for if/dm.
- FSM, counter and response routing live in the top module.

Test Plan:
- Reset, then if_req_i=1 with no loader activity -> if_gnt_o=0, fetch_enable_o=0, state_o=0.
- Loader writes 0x80..0x8C with data {A,B,C,0x00000fff} -> four mem writes, state 0->1->2, boot_done_o=1, ld_count_o=4.
- From ARMED, boot_go_i high for one cycle -> state_o=3 and fetch_enable_o=1 next cycle, held after boot_go_i drops. The same pulse in IDLE -> no change.
- RUN, if_req_i and dm_req_i held high for 4 cycles -> grants alternate dm,if,dm,if. Each rvalid arrives 1 cycle after its grant with the mem_rdata_i value driven that cycle.
- RUN, ld_req_i, if_req_i and dm_req_i all asserted -> ld_gnt_o=1 only. The next cycle grants per the unchanged round-robin pointer.
- RUN, sw_rst_i pulse during an outstanding fetch -> that if_rvalid_o still pulses. fetch_enable_o=0, ld_count_o=0, state_o=0; subsequent core requests are not granted.
